// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the load/store access unit.
// Holds the access-size and FSM state encodings plus the helpers that map a size to its masks.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_DWORD = 2'b00,
        SZ_WORD  = 2'b01,
        SZ_HALF  = 2'b10,
        SZ_BYTE  = 2'b11
    } sizeE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } stateE;

    localparam logic [2:0] ALIGN_MASK_DWORD = 3'b111;
    localparam logic [2:0] ALIGN_MASK_WORD  = 3'b011;
    localparam logic [2:0] ALIGN_MASK_HALF  = 3'b001;
    localparam logic [2:0] ALIGN_MASK_BYTE  = 3'b000;

    // Address bits that must be zero for an access of the given size.
    function automatic logic [2:0] alignMask(sizeE size);
        case (size)
            SZ_WORD: return ALIGN_MASK_WORD;
            SZ_HALF: return ALIGN_MASK_HALF;
            SZ_BYTE: return ALIGN_MASK_BYTE;
            default: return ALIGN_MASK_DWORD;
        endcase
    endfunction

    function automatic logic [63:0] laneMask(sizeE size);
        case (size)
            SZ_WORD: return 64'h0000_0000_FFFF_FFFF;
            SZ_HALF: return 64'h0000_0000_0000_FFFF;
            SZ_BYTE: return 64'h0000_0000_0000_00FF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the control-unit request/response signals and the data-memory port.
// The slave modport is the access unit's view; master is the control unit plus memory.
interface mem_access_unit_if;

    logic        req;
    logic        we;
    logic [1:0]  tam;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        done;
    logic        busy;
    logic        misaligned;
    logic [63:0] mem_addr;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport slave (
        input  req, we, tam, uns, addr, wdata, mem_rdata,
        output rdata, done, busy, misaligned, mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output req, we, tam, uns, addr, wdata, mem_rdata,
        input  rdata, done, busy, misaligned, mem_addr, mem_wr, mem_wdata
    );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering between a 64-bit memory doubleword and a sub-doubleword access.
// Produces both the extended load value and the read-modify-write store doubleword.
module lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [63:0] i_memRdata,
    input  logic [63:0] i_wdata,
    input  logic [2:0]  i_offset,
    input  sizeE        i_size,
    input  logic        i_uns,
    output logic [63:0] o_loadData,
    output logic [63:0] o_storeData
);

    logic [5:0]  w_shift;
    logic [63:0] w_shifted;
    logic [63:0] w_laneMask;
    logic        w_fill;

    assign w_shift     = {i_offset, 3'b000};
    assign w_shifted   = i_memRdata >> w_shift;
    assign w_laneMask  = laneMask(i_size) << w_shift;
    assign o_storeData = (i_memRdata & ~w_laneMask) | ((i_wdata << w_shift) & w_laneMask);

    // Doubleword accesses are always aligned, so the shifted value is the raw word.
    always_comb begin
        o_loadData = w_shifted;
        w_fill     = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                w_fill     = ~i_uns & w_shifted[7];
                o_loadData = {{56{w_fill}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                w_fill     = ~i_uns & w_shifted[15];
                o_loadData = {{48{w_fill}}, w_shifted[15:0]};
            end
            SZ_WORD: begin
                w_fill     = ~i_uns & w_shifted[31];
                o_loadData = {{32{w_fill}}, w_shifted[31:0]};
            end
            default: o_loadData = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit between the control unit and a doubleword-wide data memory.
// Sub-doubleword stores are read-modify-write; misaligned requests complete at once with an error.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              Reset,
    mem_access_unit_if.slave  bus
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_READ    = ST_READ;
    localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
    localparam logic [2:0] S_WRITE   = ST_WRITE;
    localparam logic [2:0] S_DONE    = ST_DONE;
    localparam logic [2:0] S_ERR     = ST_ERR;

    logic [2:0]  r_state;
    logic        r_we;
    sizeE        r_size;
    logic        r_uns;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic [63:0] r_memWdata;

    sizeE        w_size;
    logic        w_misaligned;
    logic        w_fullStore;
    logic [63:0] w_loadData;
    logic [63:0] w_storeData;

    assign w_size       = sizeE'(bus.tam);
    assign w_misaligned = |(bus.addr[2:0] & alignMask(w_size));
    assign w_fullStore  = bus.we && (w_size == SZ_DWORD);

    lane_align u_laneAlign (
        .i_memRdata  (bus.mem_rdata),
        .i_wdata     (r_wdata),
        .i_offset    (r_addr[2:0]),
        .i_size      (r_size),
        .i_uns       (r_uns),
        .o_loadData  (w_loadData),
        .o_storeData (w_storeData)
    );

    // Requests are only sampled in IDLE; everything the access needs is captured on that edge.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_size     <= SZ_DWORD;
            r_uns      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_memWdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_size  <= w_size;
                        r_uns   <= bus.uns;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        if (w_misaligned) begin
                            r_state <= S_ERR;
                        end else if (w_fullStore) begin
                            r_memWdata <= bus.wdata;
                            r_state    <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    if (r_we) begin
                        r_memWdata <= w_storeData;
                        r_state    <= S_WRITE;
                    end else begin
                        r_rdata <= w_loadData;
                        r_state <= S_DONE;
                    end
                end
                S_WRITE: r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE) || (r_state == S_ERR);
    assign bus.misaligned = (r_state == S_ERR);
    assign bus.mem_wr     = (r_state == S_WRITE);
    assign bus.mem_addr   = {r_addr[63:3], 3'b000};
    assign bus.mem_wdata  = r_memWdata;
    assign bus.rdata      = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a vector table driven through a scoreboard, plus
// hand-built sequences for reset mid-access, req during busy and req held high.
module tb_mem_access_unit;

    typedef struct {
        logic        we;
        logic [1:0]  tam;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] expRdata;
        logic        expMis;
        int          expLat;
        logic [63:0] expMem;
    } vecT;

    typedef struct {
        int          idx;
        int          acc;
        int          lat;
        logic        mis;
        logic [63:0] rdata;
        logic [63:0] memWord;
        logic [4:0]  memIdx;
        int          writes;
    } sbT;

    logic        clk;
    logic        Reset;
    logic        memLoad;
    int          cycleCnt = 0;
    int          doneSeen = 0;
    int          wrCount = 0;
    int          wrTotal = 0;
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [63:0] mem [0:31];
    sbT          sbQ[$];
    vecT         vecs[21];

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Data memory: registered read one cycle after the address, write on mem_wr.
    always @(posedge clk) begin
        if (memLoad) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem[0] <= 64'h8000_0000_0000_0000;
            mem[1] <= 64'hF0E1_D2C3_B4A5_9687;
            mem[2] <= 64'h0000_0000_0000_80FF;
            mem[4] <= 64'h1122_3344_5566_7788;
            mem[6] <= 64'h0123_4567_89AB_CDEF;
            bus.mem_rdata <= '0;
        end else begin
            bus.mem_rdata <= mem[bus.mem_addr[7:3]];
            if (bus.mem_wr) mem[bus.mem_addr[7:3]] <= bus.mem_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every done pops one scoreboard entry and checks the completed access.
    always @(negedge clk) begin
        if (Reset) begin
            wrCount = 0;
        end else begin
            if (bus.mem_wr) begin
                wrCount++;
                wrTotal++;
            end
            if (bus.misaligned && !bus.done) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL misaligned_without_done: got misaligned=1 done=0, expected both together");
            end
            if (bus.done) begin
                doneSeen++;
                if (sbQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL spurious_done: got done with empty scoreboard, expected no done");
                end else begin
                    sbT e;
                    e = sbQ.pop_front();
                    checkOutput($sformatf("v%0d_latency", e.idx), 64'(cycleCnt - e.acc + 1), 64'(e.lat));
                    checkOutput($sformatf("v%0d_misaligned", e.idx), 64'(bus.misaligned), 64'(e.mis));
                    checkOutput($sformatf("v%0d_rdata", e.idx), bus.rdata, e.rdata);
                    checkOutput($sformatf("v%0d_write_count", e.idx), 64'(wrCount), 64'(e.writes));
                    checkOutput($sformatf("v%0d_mem_word", e.idx), mem[e.memIdx], e.memWord);
                    checkOutput($sformatf("v%0d_busy_at_done", e.idx), 64'(bus.busy), 64'd1);
                end
                wrCount = 0;
            end
        end
    end

    task automatic waitIdle();
        @(negedge clk);
        for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
    endtask

    task automatic pushExpected(input int idx, input vecT v, input int acc);
        sbT e;
        e.idx     = idx;
        e.acc     = acc;
        e.lat     = v.expLat;
        e.mis     = v.expMis;
        e.rdata   = v.expRdata;
        e.memWord = v.expMem;
        e.memIdx  = v.addr[7:3];
        e.writes  = (v.we && !v.expMis) ? 1 : 0;
        sbQ.push_back(e);
    endtask

    task automatic driveFields(input vecT v);
        bus.we    = v.we;
        bus.tam   = v.tam;
        bus.uns   = v.uns;
        bus.addr  = v.addr;
        bus.wdata = v.wdata;
    endtask

    task automatic scramble();
        bus.we    = ~bus.we;
        bus.tam   = 2'($urandom());
        bus.uns   = ~bus.uns;
        bus.addr  = {$urandom(), $urandom()};
        bus.wdata = {$urandom(), $urandom()};
    endtask

    task automatic waitDones(input int idx, input int start, input int count);
        for (int k = 0; k < 30 && (doneSeen - start) < count; k++) @(posedge clk);
        if ((doneSeen - start) < count) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL v%0d_timeout: got %0d done pulses, expected %0d", idx, doneSeen - start, count);
            sbQ.delete();
        end
    endtask

    task automatic applyStimulus(input int idx, input vecT v);
        int start;
        waitIdle();
        start = doneSeen;
        pushExpected(idx, v, cycleCnt + 1);
        driveFields(v);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        scramble();
        waitDones(idx, start, 1);
        @(negedge clk);
        checkOutput($sformatf("v%0d_idle_after_done", idx), 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecT v;
        int  start;

        vecs[0]  = '{1'b0, 2'b11, 1'b0, 64'h11, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 64'h0000_0000_0000_80FF};
        vecs[1]  = '{1'b0, 2'b11, 1'b1, 64'h11, 64'h0, 64'h0000_0000_0000_0080, 1'b0, 3, 64'h0000_0000_0000_80FF};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_80FF, 1'b0, 3, 64'h0000_0000_0000_80FF};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 64'h0C, 64'h0, 64'h0000_0000_F0E1_D2C3, 1'b0, 3, 64'hF0E1_D2C3_B4A5_9687};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 64'h0C, 64'h0, 64'hFFFF_FFFF_F0E1_D2C3, 1'b0, 3, 64'hF0E1_D2C3_B4A5_9687};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 64'h0A, 64'h0, 64'hFFFF_FFFF_FFFF_B4A5, 1'b0, 3, 64'hF0E1_D2C3_B4A5_9687};
        vecs[6]  = '{1'b0, 2'b11, 1'b1, 64'h0F, 64'h0, 64'h0000_0000_0000_00F0, 1'b0, 3, 64'hF0E1_D2C3_B4A5_9687};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 64'h08, 64'h0, 64'hF0E1_D2C3_B4A5_9687, 1'b0, 3, 64'hF0E1_D2C3_B4A5_9687};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 64'h22, 64'hFFFF_0000_0000_ABCD, 64'hF0E1_D2C3_B4A5_9687, 1'b0, 4, 64'h1122_3344_ABCD_7788};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 64'h24, 64'h0, 64'h0000_0000_1122_3344, 1'b0, 3, 64'h1122_3344_ABCD_7788};
        vecs[10] = '{1'b1, 2'b11, 1'b0, 64'h25, 64'h1234_5678_9ABC_DE5A, 64'h0000_0000_1122_3344, 1'b0, 4, 64'h1122_5A44_ABCD_7788};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 64'h20, 64'h1234_5678_CAFE_BABE, 64'h0000_0000_1122_3344, 1'b0, 4, 64'h1122_5A44_CAFE_BABE};
        vecs[12] = '{1'b1, 2'b00, 1'b0, 64'h18, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_1122_3344, 1'b0, 2, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[13] = '{1'b0, 2'b00, 1'b0, 64'h18, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 3, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[14] = '{1'b0, 2'b01, 1'b0, 64'h06, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1, 64'h8000_0000_0000_0000};
        vecs[15] = '{1'b0, 2'b10, 1'b0, 64'h13, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1, 64'h0000_0000_0000_80FF};
        vecs[16] = '{1'b1, 2'b00, 1'b0, 64'h1C, 64'h5555_5555_5555_5555, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[17] = '{1'b1, 2'b10, 1'b0, 64'h21, 64'h0000_0000_0000_9999, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1, 64'h1122_5A44_CAFE_BABE};
        vecs[18] = '{1'b0, 2'b11, 1'b0, 64'h07, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 64'h8000_0000_0000_0000};
        vecs[19] = '{1'b0, 2'b10, 1'b1, 64'h06, 64'h0, 64'h0000_0000_0000_8000, 1'b0, 3, 64'h8000_0000_0000_0000};
        vecs[20] = '{1'b0, 2'b01, 1'b0, 64'h04, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0, 3, 64'h8000_0000_0000_0000};

        Reset     = 1'b1;
        memLoad   = 1'b1;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.tam   = 2'b00;
        bus.uns   = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        #3;
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_misaligned", 64'(bus.misaligned), 64'd0);
        checkOutput("reset_mem_wr", 64'(bus.mem_wr), 64'd0);
        checkOutput("reset_rdata", bus.rdata, 64'd0);
        checkOutput("reset_mem_wdata", bus.mem_wdata, 64'd0);
        checkOutput("reset_mem_addr", bus.mem_addr, 64'd0);
        repeat (2) @(negedge clk);
        memLoad = 1'b0;
        @(negedge clk);
        Reset = 1'b0;

        for (int i = 0; i < 21; i++) applyStimulus(i, vecs[i]);

        // Reset lands while a half store sits in CAPTURE; no write may follow.
        waitIdle();
        start = wrTotal;
        v = '{1'b1, 2'b10, 1'b0, 64'h32, 64'h0000_0000_0000_7777, 64'h0, 1'b0, 4, 64'h0};
        driveFields(v);
        bus.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(posedge clk);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("rst_mid_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_mid_done", 64'(bus.done), 64'd0);
        checkOutput("rst_mid_mem_wr", 64'(bus.mem_wr), 64'd0);
        checkOutput("rst_mid_rdata", bus.rdata, 64'd0);
        checkOutput("rst_mid_mem_addr", bus.mem_addr, 64'd0);
        checkOutput("rst_mid_mem_wdata", bus.mem_wdata, 64'd0);
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        checkOutput("rst_mid_no_write", 64'(wrTotal - start), 64'd0);
        checkOutput("rst_mid_mem_untouched", mem[6], 64'h0123_4567_89AB_CDEF);
        v = '{1'b0, 2'b01, 1'b1, 64'h04, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 3, 64'h8000_0000_0000_0000};
        applyStimulus(30, v);

        // A second req pulsed while the store is busy must be dropped.
        waitIdle();
        start = doneSeen;
        v = '{1'b1, 2'b10, 1'b0, 64'h34, 64'h0000_0000_0000_1234, 64'h0000_0000_8000_0000, 1'b0, 4, 64'h0123_1234_89AB_CDEF};
        pushExpected(40, v, cycleCnt + 1);
        driveFields(v);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.tam  = 2'b11;
        bus.addr = 64'h10;
        @(negedge clk);
        bus.req = 1'b0;
        waitDones(40, start, 1);
        repeat (8) @(negedge clk);
        checkOutput("busy_req_done_count", 64'(doneSeen - start), 64'd1);

        // req held high on a misaligned access restarts only from IDLE: every other cycle.
        waitIdle();
        start = doneSeen;
        v = '{1'b0, 2'b10, 1'b0, 64'h13, 64'h0, 64'h0000_0000_8000_0000, 1'b1, 1, 64'h0000_0000_0000_80FF};
        for (int j = 0; j < 4; j++) pushExpected(50 + j, v, cycleCnt + 1 + 2 * j);
        driveFields(v);
        bus.req = 1'b1;
        repeat (7) @(negedge clk);
        bus.req = 1'b0;
        waitDones(50, start, 4);
        repeat (4) @(negedge clk);
        checkOutput("held_req_done_count", 64'(doneSeen - start), 64'd4);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
